// File: rtl/tlc_pkg.sv
// Shared definitions for the two-direction intersection controller:
// state encodings, 7-segment digit patterns and small helpers.
package tlc_pkg;

  typedef enum logic [2:0] {
    ST_ALL_RED_B2A = 3'd0,
    ST_A_GREEN     = 3'd1,
    ST_A_YELLOW    = 3'd2,
    ST_ALL_RED_A2B = 3'd3,
    ST_B_GREEN     = 3'd4,
    ST_B_YELLOW    = 3'd5,
    ST_NIGHT       = 3'd6
  } tlc_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high segments, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 7'h3F;
      4'd1:    seg_digit = 7'h06;
      4'd2:    seg_digit = 7'h5B;
      4'd3:    seg_digit = 7'h4F;
      4'd4:    seg_digit = 7'h66;
      4'd5:    seg_digit = 7'h6D;
      4'd6:    seg_digit = 7'h7D;
      4'd7:    seg_digit = 7'h07;
      4'd8:    seg_digit = 7'h7F;
      4'd9:    seg_digit = 7'h6F;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    max3 = (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tlc_sec_tick.sv
// One-second prescaler: counts 0..pSECOND_CNT_VAL while enabled and
// raises tick_o in the cycle the count sits at its terminal value.
module tlc_sec_tick #(
  parameter int pSECOND_CNT_VAL = 99
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = $clog2(pSECOND_CNT_VAL + 1);
  localparam logic [CW-1:0] TERM = CW'(pSECOND_CNT_VAL);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == TERM);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-direction intersection controller with countdown display and night
// flashing-yellow mode. Define TLC_PED_REQ_EN to add pedestrian green shortening.
module traffic_intersection_ctrl
  import tlc_pkg::*;
#(
  parameter int pSECOND_CNT_VAL     = 99,
  parameter int pTIME_GREEN_LIGHT   = 15,
  parameter int pTIME_YELLOW_LIGHT  = 3,
  parameter int pTIME_ALL_RED       = 2,
  parameter int pTIME_PED_MIN_GREEN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       night_mode,
`ifdef TLC_PED_REQ_EN
  input  logic       ped_req,
  output logic       ped_ack,
`endif
  output logic       a_green,
  output logic       a_yellow,
  output logic       a_red,
  output logic       b_green,
  output logic       b_yellow,
  output logic       b_red,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic [2:0] phase
);

  localparam int MAX_T   = max3(pTIME_GREEN_LIGHT, pTIME_YELLOW_LIGHT, pTIME_ALL_RED);
  localparam int CLOG_T  = $clog2(MAX_T + 1);
  // At least 4 bits so the divide-by-ten constant is representable.
  localparam int REM_W   = (CLOG_T < 4) ? 4 : CLOG_T;

  localparam logic [REM_W-1:0] T_GREEN   = REM_W'(pTIME_GREEN_LIGHT);
  localparam logic [REM_W-1:0] T_YELLOW  = REM_W'(pTIME_YELLOW_LIGHT);
  localparam logic [REM_W-1:0] T_ALL_RED = REM_W'(pTIME_ALL_RED);
  localparam logic [REM_W-1:0] T_PED_MIN = REM_W'(pTIME_PED_MIN_GREEN);
  localparam logic [REM_W-1:0] ONE       = REM_W'(1);
  localparam logic [REM_W-1:0] TEN       = REM_W'(10);

  tlc_state_e       state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             flash_q, flash_d;
  logic             night_pend_q, night_pend_d;
  logic             night_req;
  logic             ped_pend;
  logic             is_green;
  logic             shorten_ok;
  logic             tick;
  logic [3:0]       tens_dig, ones_dig;

  tlc_sec_tick #(
    .pSECOND_CNT_VAL(pSECOND_CNT_VAL)
  ) u_sec_tick (
    .clk   (clk),
    .rst   (rst),
    .en_i  (en),
    .tick_o(tick)
  );

  function automatic logic [REM_W-1:0] dur_of(input tlc_state_e s);
    case (s)
      ST_A_GREEN, ST_B_GREEN:   dur_of = T_GREEN;
      ST_A_YELLOW, ST_B_YELLOW: dur_of = T_YELLOW;
      default:                  dur_of = T_ALL_RED;
    endcase
  endfunction

  assign night_req  = night_pend_q | night_mode;
  assign is_green   = (state_q == ST_A_GREEN) || (state_q == ST_B_GREEN);
  assign shorten_ok = is_green && ped_pend && (rem_q > T_PED_MIN);

  // Next-state: phases advance only on ticks; night is entered only from an
  // expiring all-red so a direction is never cut off mid-green.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    flash_d      = flash_q;
    night_pend_d = (state_q == ST_NIGHT) ? 1'b0 : night_req;
    if (tick) begin
      if (state_q == ST_NIGHT) begin
        if (!night_mode) begin
          state_d = ST_ALL_RED_B2A;
          rem_d   = T_ALL_RED;
        end else begin
          flash_d = ~flash_q;
        end
      end else if (shorten_ok) begin
        rem_d = T_PED_MIN;
      end else if (rem_q != ONE) begin
        rem_d = rem_q - ONE;
      end else begin
        case (state_q)
          ST_ALL_RED_B2A: state_d = night_req ? ST_NIGHT : ST_A_GREEN;
          ST_A_GREEN:     state_d = ST_A_YELLOW;
          ST_A_YELLOW:    state_d = ST_ALL_RED_A2B;
          ST_ALL_RED_A2B: state_d = night_req ? ST_NIGHT : ST_B_GREEN;
          ST_B_GREEN:     state_d = ST_B_YELLOW;
          ST_B_YELLOW:    state_d = ST_ALL_RED_B2A;
          default:        state_d = ST_ALL_RED_B2A;
        endcase
        rem_d = dur_of(state_d);
        if (state_d == ST_NIGHT) begin
          flash_d      = 1'b1;
          night_pend_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ALL_RED_B2A;
      rem_q        <= T_ALL_RED;
      flash_q      <= 1'b0;
      night_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      flash_q      <= flash_d;
      night_pend_q <= night_pend_d;
    end
  end

`ifdef TLC_PED_REQ_EN
  logic ped_pend_q, ped_pend_d;
  logic enter_clear;

  // Pending request is dropped whenever the intersection clears to all-red or night.
  assign enter_clear = (state_d != state_q) &&
                       ((state_d == ST_ALL_RED_B2A) || (state_d == ST_ALL_RED_A2B) ||
                        (state_d == ST_NIGHT));

  always_comb begin
    ped_pend_d = ped_pend_q | ped_req;
    if (enter_clear) begin
      ped_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_pend_q <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
    end
  end

  assign ped_pend = ped_pend_q;
  assign ped_ack  = tick && shorten_ok;
`else
  assign ped_pend = 1'b0;
`endif

  assign tens_dig = 4'(rem_q / TEN);
  assign ones_dig = 4'(rem_q % TEN);
  assign phase    = state_q;

  always_comb begin
    a_green  = 1'b0;
    a_yellow = 1'b0;
    a_red    = 1'b0;
    b_green  = 1'b0;
    b_yellow = 1'b0;
    b_red    = 1'b0;
    seg_tens = seg_digit(tens_dig);
    seg_ones = seg_digit(ones_dig);
    case (state_q)
      ST_A_GREEN:  begin a_green  = 1'b1; b_red    = 1'b1; end
      ST_A_YELLOW: begin a_yellow = 1'b1; b_red    = 1'b1; end
      ST_B_GREEN:  begin a_red    = 1'b1; b_green  = 1'b1; end
      ST_B_YELLOW: begin a_red    = 1'b1; b_yellow = 1'b1; end
      ST_NIGHT: begin
        a_yellow = flash_q;
        b_yellow = flash_q;
        seg_tens = SEG_BLANK;
        seg_ones = SEG_BLANK;
      end
      default: begin a_red = 1'b1; b_red = 1'b1; end
    endcase
  end

endmodule
